muldiv_seq: RTL and testbench

Iterative unsigned multiply/divide sequencer for the RV32 ALU. It executes one MUL, MULHU, DIVU or REMU operation at a time, one radix-2 step per clock, using a single `Adder_32` instance. It sits beside the single-cycle adder/shifter datapath and serves the execute stage through a valid/ready request/response pair.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_seq_adder.sv | 15 +
 rtl/muldiv_seq.sv | 109 ++++++++++
 tb/tb_muldiv_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int STEPS = 32;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    function automatic logic is_mul(input op_e op);
        return !op[1];
    endfunction

endpackage

// File: rtl/muldiv_seq_adder.sv
// 32-bit add/subtract; overflow is the raw carry-out in both modes.
module Adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic        overflow
);

    logic [31:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign {overflow, s} = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};

endmodule

// File: rtl/muldiv_seq.sv
// Radix-2 sequencer for MUL/MULHU/DIVU/REMU: one step per clock,
// 32 steps per op, one shared adder.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result
);

    import muldiv_pkg::*;

    state_e          state;
    op_e             op;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [4:0]      cnt;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] sum;
    logic            carry;
    logic            mul_op;
    op_e             new_op;

    // hi/lo double as rem/quo, opnd as mcand/dvsr
    assign mul_op  = is_mul(op);
    assign new_op  = op_e'(req_op);
    assign shifted = {hi[XLEN-2:0], lo[XLEN-1]};
    assign add_a   = mul_op ? hi : shifted;

    Adder_32 u_add (
        .a       (add_a),
        .b       (opnd),
        .sub     (!mul_op),
        .s       (sum),
        .overflow(carry)
    );

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);

    always_comb begin
        rsp_result = '0;
        if (state == S_DONE) begin
            unique case (op)
                OP_MUL:   rsp_result = lo;
                OP_MULHU: rsp_result = hi;
                OP_DIVU:  rsp_result = lo;
                OP_REMU:  rsp_result = hi;
                default:  rsp_result = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= OP_MUL;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= S_BUSY;
                        op    <= new_op;
                        cnt   <= '0;
                        hi    <= '0;
                        lo    <= is_mul(new_op) ? req_b : req_a;
                        opnd  <= is_mul(new_op) ? req_a : req_b;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_STEP) state <= S_DONE;
                    if (mul_op) begin
                        if (lo[0]) {hi, lo} <= {carry, sum, lo[XLEN-1:1]};
                        else       {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
                    end else begin
                        // a set top bit means shifted exceeds any divisor
                        if (hi[XLEN-1] | carry) begin
                            hi <= sum;
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= shifted;
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: reference model feeds a queue at accept.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // called and returning at a falling edge; accept happens at the next rise
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_result} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b result=%h required 1 0 0",
                     req_ready, rsp_valid, rsp_result);
        end
    endtask

    task automatic test_ops(input string name, input logic [1:0] ops[],
                            input logic [31:0] as[], input logic [31:0] bs[]);
        int lat;
        logic [31:0] want;
        foreach (ops[i]) begin
            issue(ops[i], as[i], bs[i]);
            wait_rsp(lat);
            total++;
            if (lat !== 32) begin
                bad++;
                $display("FAIL %s_latency[%0d]: got %0d required 32", name, i, lat);
            end
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            total++;
            if (rsp_result !== want) begin
                bad++;
                $display("FAIL %s_result[%0d]: got %h required %h",
                         name, i, rsp_result, want);
            end
            take_rsp();
        end
    endtask

    task automatic test_mul();
        test_ops("mul", '{2'b00, 2'b01, 2'b00, 2'b01},
                 '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                 '{32'd6, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    endtask

    task automatic test_div();
        test_ops("div", '{2'b10, 2'b11, 2'b10},
                 '{32'd100, 32'd100, 32'h8000_0000},
                 '{32'd7, 32'd7, 32'd1});
    endtask

    task automatic test_div_zero();
        test_ops("divzero", '{2'b10, 2'b11},
                 '{32'h1234_5678, 32'h1234_5678}, '{32'd0, 32'd0});
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] held;
        logic [31:0] want;
        issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
        wait_rsp(lat);
        held = rsp_result;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        total++;
        if (rsp_result !== want) begin
            bad++;
            $display("FAIL bp_result: got %h required %h", rsp_result, want);
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = (i == 4);
            req_op = 2'b00;
            req_a = 32'd9;
            req_b = 32'd9;
            @(negedge clk);
            total++;
            if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, held}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h required 1 0 %h",
                         i, rsp_valid, req_ready, rsp_result, held);
            end
        end
        req_valid = 1'b0;
        take_rsp();
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release: ready=%b valid=%b required 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b10, 32'hCAFE_F00D, 32'd13);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        total++;
        if ({req_ready, rsp_valid, rsp_result} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h required 1 0 0",
                     req_ready, rsp_valid, rsp_result);
        end
        test_ops("after_rst", '{2'b00}, '{32'd3}, '{32'd5});
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] want;
        for (int i = 0; i < 6; i++) begin
            issue(2'($urandom), $urandom, (i == 5) ? 32'd0 : $urandom >> (i * 5));
            wait_rsp(lat);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            total++;
            if (lat !== 32 || rsp_result !== want) begin
                bad++;
                $display("FAIL b2b[%0d]: lat=%0d got %h required 32 %h",
                         i, lat, rsp_result, want);
            end
            take_rsp();
            total++;
            if ({req_ready, rsp_valid} !== 2'b10) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: ready=%b valid=%b required 1 0",
                         i, req_ready, rsp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
